// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
//   Bundle of the load/store port between the core (master) and the data
//   memory responder (slave).
//   Request : req_valid, req_ready, req_we, req_size[1:0], req_addr[31:0],
//             req_wdata[31:0]
//   Response: resp_valid, resp_rdata[31:0], resp_err
//   Hazard  : stall (responder -> core hazard unit)
// -----------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Memory-side end of the core's load/store port. Accepts one request at a
//   time, waits LATENCY cycles, then returns a one-cycle response. Stores are
//   byte/half/word with lane steering; loads are right-aligned and
//   zero-extended. Misaligned, illegal-size and out-of-range requests fault.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset (memory contents are not reset)
//   bus  - dmem_responder_if.slave: request handshake, response, stall
//
// Parameters:
//   ADDR_W    - word-address bits (depth 2^ADDR_W x 32)
//   LATENCY   - cycles from acceptance to response (>= 1)
//   INIT_FILE - hex image path (no preload is performed in this build)
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_W    = 10,
  parameter int LATENCY   = 2,
  parameter     INIT_FILE = "dmem.hex"
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // ---------------------------------------------------------------------------
  // Control state and captured request
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cap_we_q, cap_we_d;
  logic [1:0]       cap_size_q, cap_size_d;
  logic [31:0]      cap_addr_q, cap_addr_d;
  logic [31:0]      cap_wdata_q, cap_wdata_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_we_d    = cap_we_q;
    cap_size_d  = cap_size_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          cap_we_d    = bus.req_we;
          cap_size_d  = bus.req_size;
          cap_addr_d  = bus.req_addr;
          cap_wdata_d = bus.req_wdata;
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cap_we_q    <= 1'b0;
      cap_size_q  <= '0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_we_q    <= cap_we_d;
      cap_size_q  <= cap_size_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Access decode. With LATENCY = 1 the array is touched on the acceptance
  // edge itself, before the capture registers hold the request, so the
  // live request fields are used while still in IDLE.
  // ---------------------------------------------------------------------------
  logic              acc_we;
  logic [1:0]        acc_size;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [1:0]        acc_off;
  logic [ADDR_W-1:0] acc_idx;
  logic              acc_err;
  logic              enter_resp;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic              wr_en;

  assign acc_we    = (state_q == S_IDLE) ? bus.req_we    : cap_we_q;
  assign acc_size  = (state_q == S_IDLE) ? bus.req_size  : cap_size_q;
  assign acc_addr  = (state_q == S_IDLE) ? bus.req_addr  : cap_addr_q;
  assign acc_wdata = (state_q == S_IDLE) ? bus.req_wdata : cap_wdata_q;
  assign acc_off   = acc_addr[1:0];
  assign acc_idx   = acc_addr[ADDR_W+1:2];

  assign acc_err = ((acc_size == SZ_HALF) && acc_off[0])
                 | ((acc_size == SZ_WORD) && (acc_off != 2'b00))
                 | (acc_size == 2'b11)
                 | (acc_addr[31:ADDR_W+2] != '0);

  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

  // The memory block has no reset, so writes are explicitly blocked while
  // reset is held (matters for LATENCY = 1, where IDLE + req_valid writes).
  assign wr_en = enter_resp & acc_we & ~acc_err & ~rst;

  // Per-lane byte enable and steered write data. Byte data is replicated to
  // every lane, half data to both halves; the enables pick the real target.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign lane_be[gi] = (acc_size == SZ_WORD)
                       | ((acc_size == SZ_HALF) && (acc_off[1] == LANE[1]))
                       | ((acc_size == SZ_BYTE) && (acc_off == LANE));
    assign lane_wdata[gi*8 +: 8] =
        (acc_size == SZ_BYTE) ? acc_wdata[7:0] :
        (acc_size == SZ_HALF) ? (LANE[0] ? acc_wdata[15:8] : acc_wdata[7:0]) :
                                acc_wdata[gi*8 +: 8];
  end

  // ---------------------------------------------------------------------------
  // Storage: byte-write array with a registered read port.
  // ---------------------------------------------------------------------------
  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word_q;

  logic unused_init_file;
  assign unused_init_file = ^INIT_FILE;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_be[i]) mem[acc_idx][i*8 +: 8] <= lane_wdata[i*8 +: 8];
      end
    end
    if (enter_resp) rd_word_q <= mem[acc_idx];
  end

  // ---------------------------------------------------------------------------
  // Response qualifiers, latched on the edge that enters RESP.
  // ---------------------------------------------------------------------------
  logic       rsp_err_q, rsp_err_d;
  logic       rsp_load_q, rsp_load_d;
  logic [1:0] rsp_off_q, rsp_off_d;
  logic [1:0] rsp_size_q, rsp_size_d;

  always_comb begin
    rsp_err_d  = rsp_err_q;
    rsp_load_d = rsp_load_q;
    rsp_off_d  = rsp_off_q;
    rsp_size_d = rsp_size_q;
    if (enter_resp) begin
      rsp_err_d  = acc_err;
      rsp_load_d = ~acc_we & ~acc_err;
      rsp_off_d  = acc_off;
      rsp_size_d = acc_size;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
      rsp_off_q  <= '0;
      rsp_size_q <= '0;
    end else begin
      rsp_err_q  <= rsp_err_d;
      rsp_load_q <= rsp_load_d;
      rsp_off_q  <= rsp_off_d;
      rsp_size_q <= rsp_size_d;
    end
  end

  // Lane extraction from the registered read word: right-align, zero-extend.
  logic [31:0] rd_shifted;
  logic [31:0] rd_aligned;

  always_comb begin
    rd_shifted = rd_word_q >> {rsp_off_q, 3'b000};
    case (rsp_size_q)
      SZ_BYTE: rd_aligned = {24'd0, rd_shifted[7:0]};
      SZ_HALF: rd_aligned = {16'd0, rd_shifted[15:0]};
      default: rd_aligned = rd_shifted;
    endcase
  end

  logic resp_active;
  assign resp_active = (state_q == S_RESP);

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = resp_active;
  assign bus.resp_err   = resp_active & rsp_err_q;
  assign bus.resp_rdata = (resp_active & rsp_load_q) ? rd_aligned : 32'd0;
  // Low during RESP so the core advances in the same cycle the data arrives.
  assign bus.stall      = (state_q == S_WAIT) | ((state_q == S_IDLE) & bus.req_valid);

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed bench for dmem_responder. Two instances share the request
//   stimulus: u_dut (LATENCY = 2) and u_dut_l1 (LATENCY = 1); sel_b routes
//   req_valid and the observed outputs to one of them.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        sel_b;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  int n_vec;
  int n_miss;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  assign bus_a.req_valid = req_valid & ~sel_b;
  assign bus_a.req_we    = req_we;
  assign bus_a.req_size  = req_size;
  assign bus_a.req_addr  = req_addr;
  assign bus_a.req_wdata = req_wdata;

  assign bus_b.req_valid = req_valid & sel_b;
  assign bus_b.req_we    = req_we;
  assign bus_b.req_size  = req_size;
  assign bus_b.req_addr  = req_addr;
  assign bus_b.req_wdata = req_wdata;

  logic        ready_w;
  logic        rvalid_w;
  logic [31:0] rdata_w;
  logic        rerr_w;
  logic        stall_w;

  assign ready_w  = sel_b ? bus_b.req_ready  : bus_a.req_ready;
  assign rvalid_w = sel_b ? bus_b.resp_valid : bus_a.resp_valid;
  assign rdata_w  = sel_b ? bus_b.resp_rdata : bus_a.resp_rdata;
  assign rerr_w   = sel_b ? bus_b.resp_err   : bus_a.resp_err;
  assign stall_w  = sel_b ? bus_b.stall      : bus_a.stall;

  dmem_responder #(.ADDR_W(10), .LATENCY(2), .INIT_FILE("dmem.hex")) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(1), .INIT_FILE("dmem.hex")) u_dut_l1 (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction: handshake, latency/stall/ready checks, response
  // capture, and a check that the response outputs return to zero afterwards.
  task automatic do_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int   exp_lat;
    int   lat;
    logic seen;
    logic wait_bad;
    logic stall_resp;
    exp_lat    = sel_b ? 1 : 2;
    lat        = 0;
    seen       = 1'b0;
    wait_bad   = 1'b0;
    stall_resp = 1'b1;
    rdata      = '0;
    err        = 1'b0;
    @(negedge clk);
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    #1;
    check_val("ready_idle", {31'd0, ready_w}, 32'd1);
    check_val("stall_req", {31'd0, stall_w}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge clk);
      if (rvalid_w) begin
        seen       = 1'b1;
        lat        = c;
        rdata      = rdata_w;
        err        = rerr_w;
        stall_resp = stall_w;
      end else if (!stall_w || ready_w) begin
        wait_bad = 1'b1;
      end
    end
    check_val("resp_seen", {31'd0, seen}, 32'd1);
    check_val("latency", lat, exp_lat);
    check_val("stall_in_resp", {31'd0, stall_resp}, 32'd0);
    check_val("wait_stall_ready", {31'd0, wait_bad}, 32'd0);
    @(negedge clk);
    check_val("rvalid_drop", {31'd0, rvalid_w}, 32'd0);
    check_val("rdata_idle", rdata_w, 32'd0);
    check_val("ready_back", {31'd0, ready_w}, 32'd1);
    $display("txn dut=%0s we=%0d size=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             sel_b ? "L1" : "L2", we, size, addr, wdata, rdata, err, lat);
  endtask

  task automatic expect_txn(input string tag, input logic we, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    do_req(we, size, addr, wdata, rd, er);
    check_val({tag, "_rdata"}, rd, exp_rdata);
    check_val({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    int n_resp;
    int n_bad;
    int n_rv;
    n_vec     = 0;
    n_miss    = 0;
    rst       = 1'b1;
    sel_b     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check_val("rst_ready", {31'd0, ready_w}, 32'd1);
    check_val("rst_rvalid", {31'd0, rvalid_w}, 32'd0);
    check_val("rst_rdata", rdata_w, 32'd0);
    check_val("rst_err", {31'd0, rerr_w}, 32'd0);
    check_val("rst_stall", {31'd0, stall_w}, 32'd0);

    // Word store then load
    expect_txn("st_w10", 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    expect_txn("ld_w10", 1'b0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Lane steering; junk in unused wdata bits must not leak
    expect_txn("st_w20", 1'b1, 2'b10, 32'h20, 32'h00000000, 32'h0, 1'b0);
    expect_txn("st_b22", 1'b1, 2'b00, 32'h22, 32'hFFFFFFAB, 32'h0, 1'b0);
    expect_txn("st_h20", 1'b1, 2'b01, 32'h20, 32'hFFFF1234, 32'h0, 1'b0);
    expect_txn("ld_w20", 1'b0, 2'b10, 32'h20, 32'h0, 32'h00AB1234, 1'b0);
    expect_txn("ld_b22", 1'b0, 2'b00, 32'h22, 32'h0, 32'h000000AB, 1'b0);
    expect_txn("ld_h20", 1'b0, 2'b01, 32'h20, 32'h0, 32'h00001234, 1'b0);
    expect_txn("ld_h22", 1'b0, 2'b01, 32'h22, 32'h0, 32'h000000AB, 1'b0);
    expect_txn("ld_b23", 1'b0, 2'b00, 32'h23, 32'h0, 32'h00000000, 1'b0);

    // Zero extension of values with the top bit set
    expect_txn("st_w24", 1'b1, 2'b10, 32'h24, 32'hCAFEF00D, 32'h0, 1'b0);
    expect_txn("st_b27", 1'b1, 2'b00, 32'h27, 32'h00000080, 32'h0, 1'b0);
    expect_txn("ld_b27", 1'b0, 2'b00, 32'h27, 32'h0, 32'h00000080, 1'b0);
    expect_txn("ld_h26", 1'b0, 2'b01, 32'h26, 32'h0, 32'h000080FE, 1'b0);
    expect_txn("ld_h24", 1'b0, 2'b01, 32'h24, 32'h0, 32'h0000F00D, 1'b0);
    expect_txn("ld_b25", 1'b0, 2'b00, 32'h25, 32'h0, 32'h000000F0, 1'b0);
    expect_txn("ld_w24", 1'b0, 2'b10, 32'h24, 32'h0, 32'h80FEF00D, 1'b0);

    // Misaligned / illegal: fault, no write, rdata 0
    expect_txn("st_h21", 1'b1, 2'b01, 32'h21, 32'h0000FFFF, 32'h0, 1'b1);
    expect_txn("ld_w22", 1'b0, 2'b10, 32'h22, 32'h0, 32'h0, 1'b1);
    expect_txn("ld_h23", 1'b0, 2'b01, 32'h23, 32'h0, 32'h0, 1'b1);
    expect_txn("st_sz3", 1'b1, 2'b11, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1);
    expect_txn("ld_sz3", 1'b0, 2'b11, 32'h20, 32'h0, 32'h0, 1'b1);
    expect_txn("ld_w20b", 1'b0, 2'b10, 32'h20, 32'h0, 32'h00AB1234, 1'b0);

    // Out of range (word index aliases 0x20 in the low bits)
    expect_txn("ld_oor", 1'b0, 2'b10, 32'h00001000, 32'h0, 32'h0, 1'b1);
    expect_txn("st_oor", 1'b1, 2'b10, 32'h00001020, 32'h77777777, 32'h0, 1'b1);
    expect_txn("ld_w20c", 1'b0, 2'b10, 32'h20, 32'h0, 32'h00AB1234, 1'b0);

    // req_valid held high: one acceptance per LATENCY+1 = 3 cycles
    @(negedge clk);
    req_we    = 1'b0;
    req_size  = 2'b10;
    req_addr  = 32'h10;
    req_wdata = 32'h0;
    req_valid = 1'b1;
    n_acc  = 0;
    n_resp = 0;
    n_bad  = 0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (ready_w) n_acc++;
      if (rvalid_w) begin
        n_resp++;
        if (rdata_w !== 32'hDEADBEEF) n_bad++;
      end
      if (k == 11) req_valid = 1'b0;
    end
    $display("txn held-valid: accepts=%0d responses=%0d bad_data=%0d", n_acc, n_resp, n_bad);
    check_val("held_accepts", n_acc, 4);
    check_val("held_resps", n_resp, 4);
    check_val("held_data", n_bad, 0);
    @(negedge clk);
    check_val("held_ready_back", {31'd0, ready_w}, 32'd1);

    // LATENCY = 1 instance
    sel_b = 1'b1;
    expect_txn("l1_st_w40", 1'b1, 2'b10, 32'h40, 32'h13579BDF, 32'h0, 1'b0);
    expect_txn("l1_ld_w40", 1'b0, 2'b10, 32'h40, 32'h0, 32'h13579BDF, 1'b0);
    expect_txn("l1_st_b41", 1'b1, 2'b00, 32'h41, 32'h0000005A, 32'h0, 1'b0);
    expect_txn("l1_ld_w40b", 1'b0, 2'b10, 32'h40, 32'h0, 32'h13575ADF, 1'b0);
    expect_txn("l1_ld_w42", 1'b0, 2'b10, 32'h42, 32'h0, 32'h0, 1'b1);
    sel_b = 1'b0;

    // Reset while a store is in WAIT
    expect_txn("st_w30", 1'b1, 2'b10, 32'h30, 32'h11223344, 32'h0, 1'b0);
    @(negedge clk);
    req_we    = 1'b1;
    req_size  = 2'b00;
    req_addr  = 32'h30;
    req_wdata = 32'h00000055;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_val("rst_mid_in_wait", {31'd0, stall_w}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_mid_ready", {31'd0, ready_w}, 32'd1);
    check_val("rst_mid_stall", {31'd0, stall_w}, 32'd0);
    n_rv = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rvalid_w) n_rv++;
      if (k == 1) rst = 1'b0;
    end
    $display("txn reset-in-wait: resp_valid pulses=%0d", n_rv);
    check_val("rst_mid_no_resp", n_rv, 0);
    expect_txn("ld_w30", 1'b0, 2'b10, 32'h30, 32'h0, 32'h11223344, 1'b0);
    expect_txn("ld_w10b", 1'b0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory-side end of the pipelined core's load/store port.
- Accepts one load or store request at a time over a valid/ready handshake.
- Inserts a programmable number of wait cycles, then returns a one-cycle response.
- Drives a stall line into the core's hazard unit while a request is outstanding.
- Stores are byte/half/word with lane steering. Loads return zero-extended data; the core applies sign extension.

Parameters:
- ADDR_W, 10: word-address bits; depth is 2^ADDR_W 32-bit words.
- LATENCY, 2: cycles from request acceptance to response; legal values are 1 or more.
- INIT_FILE, "dmem.hex": hex image path; used only when DMEM_INIT_EN is defined.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- req_valid, input, 1: request present.
- req_ready, output, 1: responder can accept a request.
- req_we, input, 1: 1 = store, 0 = load.
- req_size, input, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_addr, input, 32: byte address.
- req_wdata, input, 32: store data, right-aligned.
- resp_valid, output, 1: response strobe, one cycle.
- resp_rdata, output, 32: load data, right-aligned and zero-extended.
- resp_err, output, 1: request faulted.
- stall, output, 1: to hazard unit; hold the pipeline.

Behaviour:
- One clock domain; reset is asynchronous and active-high, port names clk and rst.
- Reset state:
  - FSM state = IDLE; wait counter = 0.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - req_ready = 1 after reset; stall follows its combinational definition below.
  - Memory array is not reset.
- FSM has three states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. When req_valid is 1 at a clock edge, capture we/size/addr/wdata.
    - If LATENCY = 1, go to RESP.
    - Otherwise go to WAIT with counter = LATENCY-2.
  - WAIT: req_ready = 0. Counter decrements each cycle; when counter = 0, go to RESP.
  - RESP: req_ready = 0; resp_valid = 1 for exactly one cycle; then go to IDLE.
- Access timing:
  - The array access (read or write) happens on the edge that enters RESP.
  - resp_rdata and resp_err are registered and valid only while resp_valid = 1; they are 0 otherwise.
- Latency and throughput:
  - If the handshake edge ends cycle N, resp_valid is high in cycle N+LATENCY.
  - Maximum throughput is one request per LATENCY+1 cycles; there is no back-to-back acceptance out of RESP.
- stall = (state == WAIT) | (state == IDLE & req_valid). stall is low during RESP so the core advances with the data.
- Error conditions set resp_err = 1, suppress any write, and force resp_rdata = 0:
  - size = 01 with addr[0] = 1.
  - size = 10 with addr[1:0] != 0.
  - size = 11.
  - addr[31:ADDR_W+2] != 0 (out of range).
- Stores:
  - Byte: wdata[7:0] is written to lane addr[1:0].
  - Half: wdata[15:0] is written to lanes {addr[1],0} and {addr[1],1}.
  - Word: the full word is written.
  - Other lanes are untouched.
  - Store response: resp_rdata = 0, resp_err as above.
- Loads: select the lane(s) by addr[1:0] and size, right-align, zero-extend.
- Read-after-write: a load accepted after a store's RESP returns the updated data.
- req_valid while not in IDLE is ignored; the requester must hold the request until it sees req_ready.
- Reset mid-operation: the FSM returns to IDLE immediately and no response is issued.
  - A store still in WAIT is discarded (memory unchanged).
  - A store already written in RESP persists.
- Little-endian byte ordering: lane 0 = bits [7:0].

Optional Feature:
- DMEM_INIT_EN defined: the array is preloaded from INIT_FILE via $readmemh at time 0; loads before any store return image contents.
- DMEM_INIT_EN undefined: there is no preload and contents are undefined until written; the bench must write before reading.

Test Plan:
- Word store then load, LATENCY = 2:
  - Store addr 0x10, wdata 0xDEADBEEF, then load 0x10 → rdata 0xDEADBEEF, err 0.
  - resp_valid exactly 2 cycles after each handshake edge; stall high the cycle before.
- Byte/half lane steering:
  - Store word 0x00000000 to 0x20; store byte 0xAB to 0x22; store half 0x1234 to 0x20.
  - Load word 0x20 → 0x00AB1234. Load byte 0x22 → 0x000000AB. Load half 0x20 → 0x00001234.
- Misaligned and illegal requests:
  - Half store to 0x21 and word load from 0x22 → err 1, rdata 0; a subsequent word load of that word is unchanged.
  - size = 11 → err 1.
- Out of range: load from 0x00001000 with ADDR_W = 10 → err 1, rdata 0.
- Handshake timing:
  - req_valid held high continuously → req_ready pulses once per LATENCY+1 cycles; no double acceptance.
  - With LATENCY = 1, resp_valid appears the cycle after acceptance.
- Reset during WAIT of a store of 0x55 to 0x30:
  - No resp_valid is issued; state returns to IDLE and req_ready = 1.
  - A later load of 0x30 returns the prior value.
